// File: rtl/cpu_pkg.sv
// Shared core constants: widths, opcode encodings and the fetch PC select.
package cpu_pkg;

  localparam int unsigned ADDR_W = 10;
  localparam int unsigned INS_W  = 20;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned OPC_W  = 5;

  localparam logic [OPC_W-1:0] OPC_HLT    = 5'b10001;
  localparam logic [OPC_W-1:0] OPC_LD     = 5'b10100;
  localparam logic [2:0]       JMP_PREFIX = 3'b111;

  localparam logic [INS_W-1:0] NOP_INS = 20'h00000;

  // Source of the next program counter value
  typedef enum logic [1:0] {
    PC_HOLD = 2'd0,
    PC_JUMP = 2'd1,
    PC_INC  = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/pc_reg.sv
// Program counter with halt / jump / stall / increment priority and natural wrap.
module pc_reg #(
  parameter int unsigned ADDR_W = cpu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halted,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              stall,
  output logic [ADDR_W-1:0] pc,
  output logic              pc_upd_c
);
  import cpu_pkg::*;

  pc_sel_e           sel;
  logic [ADDR_W-1:0] pc_nxt;

  // Next-PC priority: halted freezes, a jump beats a stall, otherwise advance
  always_comb begin
    sel = PC_INC;
    if (halted) begin
      sel = PC_HOLD;
    end else if (jump_en) begin
      sel = PC_JUMP;
    end else if (stall) begin
      sel = PC_HOLD;
    end
  end

  assign pc_upd_c = (sel != PC_HOLD);

  // Next-PC value; the increment wraps at the address width
  always_comb begin
    pc_nxt = pc;
    case (sel)
      PC_JUMP: pc_nxt = jump_addr;
      PC_INC:  pc_nxt = pc + ADDR_W'(1);
      default: pc_nxt = pc;
    endcase
  end

  // PC register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= '0;
    end else begin
      pc <= pc_nxt;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, program memory interface, stall hold path, halt and stall counter.
module instruction_fetch_unit #(
  parameter int unsigned      ADDR_W  = cpu_pkg::ADDR_W,
  parameter int unsigned      INS_W   = cpu_pkg::INS_W,
  parameter logic [INS_W-1:0] NOP_INS = cpu_pkg::NOP_INS,
  parameter int unsigned      CNT_W   = cpu_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              stall_pm,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic [INS_W-1:0]  pm_data,
  output logic [ADDR_W-1:0] pm_addr,
  output logic              pm_rd_en,
  output logic [INS_W-1:0]  ins_pm,
  output logic              ins_valid,
  output logic [ADDR_W-1:0] pc_out,
  output logic              halted,
  output logic [CNT_W-1:0]  stall_cnt
);
  import cpu_pkg::*;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pc_hold;
  logic [INS_W-1:0]  ins_hold;
  logic              fetch_v;
  logic              pc_upd_c;
  logic              sel_hold;
  logic              hlt_seen;

  pc_reg #(
    .ADDR_W(ADDR_W)
  ) u_pc_reg (
    .clk      (clk),
    .reset    (reset),
    .halted   (halted),
    .jump_en  (jump_en),
    .jump_addr(jump_addr),
    .stall    (stall),
    .pc       (pc),
    .pc_upd_c (pc_upd_c)
  );

  // Memory interface; reads stop once the core has halted
  assign pm_addr  = pc;
  assign pm_rd_en = ~halted;

  // Hold path replays the last instruction on a registered stall, and pins HLT once halted
  assign sel_hold  = stall_pm | halted;
  assign ins_pm    = !fetch_v ? NOP_INS : (sel_hold ? ins_hold : pm_data);
  assign ins_valid = fetch_v;
  assign pc_out    = sel_hold ? pc_hold : pc_d;

  assign hlt_seen = fetch_v && (ins_pm[INS_W-1 -: OPC_W] == OPC_HLT);

  // Fetch validity: the cycle after a jump carries wrong-path memory data
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_v <= 1'b0;
    end else begin
      fetch_v <= halted || !jump_en;
    end
  end

  // Hold registers shadow the presented instruction and its address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ins_hold <= NOP_INS;
      pc_hold  <= '0;
    end else begin
      ins_hold <= ins_pm;
      pc_hold  <= pc_out;
    end
  end

  // Address of the word memory returns next cycle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_d <= '0;
    end else if (pc_upd_c) begin
      pc_d <= pc;
    end
  end

  // Sticky halt, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      halted <= 1'b0;
    end else if (hlt_seen) begin
      halted <= 1'b1;
    end
  end

  // Saturating count of stalled cycles while running
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && !halted && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a 1-cycle synchronous program memory model.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        stall_pm;
  logic        jump_en;
  logic [9:0]  jump_addr;
  logic [19:0] pm_data;
  logic [9:0]  pm_addr;
  logic        pm_rd_en;
  logic [19:0] ins_pm;
  logic        ins_valid;
  logic [9:0]  pc_out;
  logic        halted;
  logic [15:0] stall_cnt;

  int n_checks = 0;
  int n_err    = 0;

  logic [19:0] mem [1024];

  localparam logic [19:0] NOP = 20'h00000;
  localparam logic [19:0] HLT = 20'h88000;

  typedef struct {
    logic        stall;
    logic        stall_pm;
    logic        jump_en;
    logic [9:0]  jump_addr;
    logic [9:0]  pm_addr;
    logic [19:0] ins;
    logic        valid;
    logic [9:0]  pc_out;
    logic [15:0] cnt;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  instruction_fetch_unit dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .stall_pm (stall_pm),
    .jump_en  (jump_en),
    .jump_addr(jump_addr),
    .pm_data  (pm_data),
    .pm_addr  (pm_addr),
    .pm_rd_en (pm_rd_en),
    .ins_pm   (ins_pm),
    .ins_valid(ins_valid),
    .pc_out   (pc_out),
    .halted   (halted),
    .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pm_rd_en) pm_data <= mem[pm_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic expect_all(input string tag, input logic [9:0] pa, input logic [19:0] ins,
                            input logic valid, input logic [9:0] pco, input logic hl,
                            input logic rd, input logic [15:0] cnt);
    chk({tag, ".pm_addr"},   32'(pm_addr),   32'(pa));
    chk({tag, ".ins_pm"},    32'(ins_pm),    32'(ins));
    chk({tag, ".ins_valid"}, 32'(ins_valid), 32'(valid));
    chk({tag, ".pc_out"},    32'(pc_out),    32'(pco));
    chk({tag, ".halted"},    32'(halted),    32'(hl));
    chk({tag, ".pm_rd_en"},  32'(pm_rd_en),  32'(rd));
    chk({tag, ".stall_cnt"}, 32'(stall_cnt), 32'(cnt));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 20'h00100 + 20'(i);

    // stall, stall_pm, jump_en, jump_addr | pm_addr, ins_pm, valid, pc_out, stall_cnt
    vecs[0]  = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h000, NOP,       1'b0, 10'h000, 16'd0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h001, 20'h00100, 1'b1, 10'h000, 16'd0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h002, 20'h00101, 1'b1, 10'h001, 16'd0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h003, 20'h00102, 1'b1, 10'h002, 16'd0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h004, 20'h00103, 1'b1, 10'h003, 16'd0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 10'h000, 10'h005, 20'h00104, 1'b1, 10'h004, 16'd0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 10'h000, 10'h005, 20'h00104, 1'b1, 10'h004, 16'd1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h006, 20'h00105, 1'b1, 10'h005, 16'd1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 10'h3F0, 10'h007, 20'h00106, 1'b1, 10'h006, 16'd1};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h3F0, NOP,       1'b0, 10'h007, 16'd1};
    vecs[10] = '{1'b1, 1'b0, 1'b1, 10'h020, 10'h3F1, 20'h004F0, 1'b1, 10'h3F0, 16'd1};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h020, NOP,       1'b0, 10'h3F1, 16'd2};
    vecs[12] = '{1'b0, 1'b0, 1'b1, 10'h3FE, 10'h021, 20'h00120, 1'b1, 10'h020, 16'd2};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h3FE, NOP,       1'b0, 10'h021, 16'd2};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h3FF, 20'h004FE, 1'b1, 10'h3FE, 16'd2};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h000, 20'h004FF, 1'b1, 10'h3FF, 16'd2};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 10'h000, 10'h001, 20'h00100, 1'b1, 10'h000, 16'd2};

    reset = 1'b1; stall = 1'b0; stall_pm = 1'b0; jump_en = 1'b0; jump_addr = '0;
    next_cycle();
    next_cycle();
    expect_all("reset", 10'h000, NOP, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
    reset = 1'b0;

    // Free run, one-cycle stall replay, jump, jump with stall, wrap at the top address
    for (int i = 0; i < NVEC; i++) begin
      stall     = vecs[i].stall;
      stall_pm  = vecs[i].stall_pm;
      jump_en   = vecs[i].jump_en;
      jump_addr = vecs[i].jump_addr;
      #1;
      expect_all($sformatf("vec%0d", i), vecs[i].pm_addr, vecs[i].ins, vecs[i].valid,
                 vecs[i].pc_out, 1'b0, 1'b1, vecs[i].cnt);
      next_cycle();
    end
    stall = 1'b0; stall_pm = 1'b0; jump_en = 1'b0; jump_addr = '0;

    // Reset asserted mid-stall, between clock edges, clears state at once
    mem[3] = HLT;
    stall = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    expect_all("async_rst_stall", 10'h000, NOP, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
    next_cycle();
    reset = 1'b0;
    stall = 1'b0;

    // Run up to the HLT word at address 3
    for (int c = 0; c < 5; c++) begin
      #1;
      expect_all($sformatf("pre_hlt%0d", c), 10'(c),
                 (c == 0) ? NOP : ((c == 4) ? HLT : 20'h00100 + 20'(c - 1)),
                 (c != 0), (c == 0) ? 10'h000 : 10'(c - 1), 1'b0, 1'b1, 16'd0);
      next_cycle();
    end

    // Halted: PC frozen, reads off, HLT held, stall and jump have no effect
    for (int h = 0; h < 3; h++) begin
      stall     = 1'b1;
      jump_en   = (h == 1);
      jump_addr = 10'h100;
      #1;
      expect_all($sformatf("halted%0d", h), 10'h005, HLT, 1'b1, 10'h003, 1'b1, 1'b0, 16'd0);
      next_cycle();
    end
    stall = 1'b0; jump_en = 1'b0; jump_addr = '0;

    // Reset releases halt asynchronously and restarts at address 0
    #2;
    reset = 1'b1;
    #1;
    expect_all("async_rst_halt", 10'h000, NOP, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
    next_cycle();
    reset = 1'b0;
    #1;
    expect_all("restart0", 10'h000, NOP, 1'b0, 10'h000, 1'b0, 1'b1, 16'd0);
    next_cycle();
    #1;
    expect_all("restart1", 10'h001, 20'h00100, 1'b1, 10'h000, 1'b0, 1'b1, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
